serial_word_feeder: RTL and testbench

Upstream stage of the 101 sequence detector: accepts parallel words over a valid/ready handshake and streams them out one bit per clock on the detector's serial input. A one-word holding register behind the shift register lets back-to-back words leave with no idle gap, so patterns spanning a word boundary are presented intact. When no data is pending the serial output idles at 0 with `ser_valid` low.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/serial_word_feeder.sv | 104 ++++++++++
 tb/tb_serial_word_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and types for the 101 sequence detector slice
package seq_det_pkg;

    localparam int SER_WIDTH = 8;

    // Pattern the downstream detector looks for; benches use it to model the detector.
    localparam logic [2:0] DET_PATTERN = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to serial bit stream feeder with one-word holding register
module serial_word_feeder
    import seq_det_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    feeder_state_t    state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hold_v, hold_v_nxt;
    logic             accept;
    logic             at_last;
    logic [WIDTH-1:0] sh_shifted;

    // in_ready depends only on registered state so upstream never sees a comb path.
    assign in_ready   = !hold_v;
    assign accept     = in_valid && in_ready;
    assign at_last    = (state == SHIFT) && (cnt == LAST_CNT);
    assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    assign ser_valid  = (state == SHIFT);
    assign ser_bit    = ser_valid && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
    assign word_done  = at_last;
    assign busy       = (state == SHIFT) || hold_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh     <= '0;
            hold   <= '0;
            cnt    <= '0;
            hold_v <= 1'b0;
        end else begin
            state  <= state_nxt;
            sh     <= sh_nxt;
            hold   <= hold_nxt;
            cnt    <= cnt_nxt;
            hold_v <= hold_v_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        hold_nxt   = hold;
        cnt_nxt    = cnt;
        hold_v_nxt = hold_v;

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    // Held word wins over a fresh one so ordering is preserved.
                    if (hold_v) begin
                        sh_nxt     = hold;
                        cnt_nxt    = '0;
                        hold_v_nxt = 1'b0;
                        if (accept) begin
                            hold_nxt   = in_data;
                            hold_v_nxt = 1'b1;
                        end
                    end else if (accept) begin
                        sh_nxt  = in_data;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    sh_nxt  = sh_shifted;
                    cnt_nxt = cnt + CW'(1);
                    if (accept) begin
                        hold_nxt   = in_data;
                        hold_v_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - self-checking bench for serial_word_feeder
module tb_serial_word_feeder;
    import seq_det_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, ser_bit, ser_valid, word_done, busy;

    logic [7:0] in_data2;
    logic       in_valid2;
    logic       in_ready2, ser_bit2, ser_valid2, word_done2, busy2;

    int n_chk;
    int n_fail;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .word_done(word_done), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .ser_bit(ser_bit2), .ser_valid(ser_valid2),
        .word_done(word_done2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the downstream 101 detector, fed only with payload bits.
    logic [1:0] hist;
    logic       det_z;
    always @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b00;
        else if (ser_valid) hist <= {hist[0], ser_bit};
    end
    assign det_z = ser_valid && ({hist, ser_bit} == DET_PATTERN);

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       b, sv, wd, rdy, bsy, z;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic b, input logic sv,
                       input logic wd, input logic rdy, input logic bsy, input logic z);
        vec_t t;
        t.v = v; t.d = d; t.b = b; t.sv = sv; t.wd = wd; t.rdy = rdy; t.bsy = bsy; t.z = z;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic saw_valid;

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
        #1;
        chk("rst_ser_bit", 0, ser_bit, 1'b0);
        chk("rst_ser_valid", 0, ser_valid, 1'b0);
        chk("rst_word_done", 0, word_done, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_in_ready", 0, in_ready, 1'b1);
        step(); step();
        rst = 1'b0;

        // 0x05 MSB first: 0,0,0,0,0,1,0,1 with detector hit on the last bit
        add(1, 8'h05, 0,0,0,1,0,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 1,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 1,1,1,1,1,1);
        // 0xA0 then 0x5A back to back through the holding register
        add(1, 8'hA0, 0,0,0,1,0,0);
        add(1, 8'h5A, 1,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,0,1,0); add(0, 8'h00, 1,1,0,0,1,1);
        add(0, 8'h00, 0,1,0,0,1,0); add(0, 8'h00, 0,1,0,0,1,0);
        add(0, 8'h00, 0,1,0,0,1,0); add(0, 8'h00, 0,1,0,0,1,0);
        add(0, 8'h00, 0,1,1,0,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 1,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 1,1,0,1,1,1);
        add(0, 8'h00, 1,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 1,1,0,1,1,1); add(0, 8'h00, 0,1,1,1,1,0);
        // 0x01 then 0x40 offered on the last-bit cycle: direct load, 101 across boundary
        add(1, 8'h01, 0,0,0,1,0,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0);
        add(1, 8'h40, 1,1,1,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 1,1,0,1,1,1);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,0,1,1,0);
        add(0, 8'h00, 0,1,0,1,1,0); add(0, 8'h00, 0,1,1,1,1,0);
        add(0, 8'h00, 0,0,0,1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            chk("ser_bit", i, ser_bit, vecs[i].b);
            chk("ser_valid", i, ser_valid, vecs[i].sv);
            chk("word_done", i, word_done, vecs[i].wd);
            chk("in_ready", i, in_ready, vecs[i].rdy);
            chk("busy", i, busy, vecs[i].bsy);
            chk("det_z", i, det_z, vecs[i].z);
            step();
        end
        in_valid = 1'b0;

        // Reset mid-word at cnt=3 with the holding register full
        in_valid = 1'b1; in_data = 8'hFF; step();
        in_data = 8'h55; step();
        in_valid = 1'b0; in_data = 8'h00;
        step(); step();
        chk("pre_rst_busy", 0, busy, 1'b1);
        chk("pre_rst_in_ready", 0, in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ser_bit", 0, ser_bit, 1'b0);
        chk("mid_rst_ser_valid", 0, ser_valid, 1'b0);
        chk("mid_rst_busy", 0, busy, 1'b0);
        chk("mid_rst_in_ready", 0, in_ready, 1'b1);
        step(); step();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ser_valid || busy) saw_valid = 1'b1;
            step();
        end
        chk("post_rst_quiet", 0, saw_valid, 1'b0);
        in_valid = 1'b1; in_data = 8'h81; step();
        in_valid = 1'b0;
        chk("post_rst_first_bit", 0, ser_bit, 1'b1);
        chk("post_rst_valid", 0, ser_valid, 1'b1);
        for (int i = 0; i < 8; i++) step();

        // LSB-first instance: 0x01 gives 1 then seven 0s
        in_valid2 = 1'b1; in_data2 = 8'h01; step();
        in_valid2 = 1'b0; in_data2 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_ser_bit", i, ser_bit2, (i == 0));
            chk("lsb_ser_valid", i, ser_valid2, 1'b1);
            chk("lsb_word_done", i, word_done2, (i == 7));
            step();
        end
        chk("lsb_idle_valid", 0, ser_valid2, 1'b0);
        chk("lsb_idle_busy", 0, busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
